// File: rtl/instr_queue_mp_pkg.sv
// Shared instruction-queue defaults and the queue-entry field layout
// used by both fetch and decode.
package instr_queue_mp_pkg;
  localparam int IQ_DATA_WD = 64;
  localparam int IQ_DEPTH   = 16;
  localparam int IQ_PUSH_W  = 4;
  localparam int IQ_POP_W   = 2;

  localparam int IQ_INSTR_LSB = 0;
  localparam int IQ_INSTR_WD  = 32;
  localparam int IQ_PC_LSB    = 32;
  localparam int IQ_PC_WD     = 24;
  localparam int IQ_PD_LSB    = 56;
  localparam int IQ_PD_WD     = 8;

  typedef struct packed {
    logic [IQ_PD_WD-1:0]    predecode;
    logic [IQ_PC_WD-1:0]    pc;
    logic [IQ_INSTR_WD-1:0] instr;
  } iq_entry_t;
endpackage

// File: rtl/instr_queue_mp_if.sv
// Fetch/decode side bundle of the instruction queue; master is the
// fetch+decode pair, slave is the queue itself.
interface instr_queue_mp_if
  import instr_queue_mp_pkg::*;
#(
  parameter int DATA_WD = IQ_DATA_WD,
  parameter int DEPTH   = IQ_DEPTH,
  parameter int PUSH_W  = IQ_PUSH_W,
  parameter int POP_W   = IQ_POP_W
) ();
  logic                         flush;
  logic [$clog2(PUSH_W+1)-1:0]  push_num;
  logic [PUSH_W*DATA_WD-1:0]    push_data;
  logic                         push_ready;
  logic [$clog2(POP_W+1)-1:0]   pop_num;
  logic [POP_W*DATA_WD-1:0]     pop_data;
  logic [POP_W-1:0]             pop_valid;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         empty;
  logic                         full;

  modport master (
    output flush, push_num, push_data, pop_num,
    input  push_ready, pop_data, pop_valid, count, empty, full
  );

  modport slave (
    input  flush, push_num, push_data, pop_num,
    output push_ready, pop_data, pop_valid, count, empty, full
  );
endinterface

// File: rtl/instr_queue_mp_ptr_ctrl.sv
// Head/tail/count bookkeeping for the multi-port queue; all status
// outputs decode from the registered count so they never follow inputs.
module iq_ptr_ctrl #(
  parameter int DEPTH  = 16,
  parameter int PUSH_W = 4,
  parameter int POP_W  = 2,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH+1),
  parameter int PN_W   = $clog2(PUSH_W+1),
  parameter int QN_W   = $clog2(POP_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [PN_W-1:0]  push_num,
  input  logic [QN_W-1:0]  pop_num,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic             push_fire,
  output logic [CNT_W-1:0] count,
  output logic             push_ready,
  output logic [POP_W-1:0] pop_valid,
  output logic             empty,
  output logic             full
);
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] pop_eff, push_eff;

  // Room for a full-width push is judged on the registered count only.
  assign push_ready = (count_reg <= CNT_W'(DEPTH - PUSH_W));
  assign push_fire  = push_ready && (push_num != '0) && !flush;

  always_comb begin
    pop_eff    = (CNT_W'(pop_num) > count_reg) ? count_reg : CNT_W'(pop_num);
    push_eff   = push_fire ? CNT_W'(push_num) : '0;
    count_next = count_reg + push_eff - pop_eff;
    head_next  = head_reg + pop_eff[PTR_W-1:0];
    tail_next  = tail_reg + push_eff[PTR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  for (genvar gi = 0; gi < POP_W; gi++) begin : g_valid
    assign pop_valid[gi] = (count_reg > CNT_W'(gi));
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
endmodule

// File: rtl/instr_queue_mp.sv
// Multi-port in-order instruction queue between fetch and decode:
// up to PUSH_W writes and POP_W reads per cycle over a circular array.
module instr_queue_mp
  import instr_queue_mp_pkg::*;
#(
  parameter int DATA_WD = IQ_DATA_WD,
  parameter int DEPTH   = IQ_DEPTH,
  parameter int PUSH_W  = IQ_PUSH_W,
  parameter int POP_W   = IQ_POP_W
) (
  input  logic             clk,
  input  logic             rst,
  instr_queue_mp_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int PN_W  = $clog2(PUSH_W+1);

  logic [DATA_WD-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               push_fire;

  iq_ptr_ctrl #(
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W),
    .POP_W  (POP_W)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .push_num   (bus.push_num),
    .pop_num    (bus.pop_num),
    .head       (head),
    .tail       (tail),
    .push_fire  (push_fire),
    .count      (bus.count),
    .push_ready (bus.push_ready),
    .pop_valid  (bus.pop_valid),
    .empty      (bus.empty),
    .full       (bus.full)
  );

  // Storage is deliberately left unreset; only occupied slots are ever read as valid.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      for (int i = 0; i < PUSH_W; i++) begin
        if (PN_W'(i) < bus.push_num)
          mem[tail + PTR_W'(i)] <= bus.push_data[i*DATA_WD +: DATA_WD];
      end
    end
  end

  // Read straight from the array so a push is visible the cycle after its edge.
  for (genvar gi = 0; gi < POP_W; gi++) begin : g_rd
    assign bus.pop_data[gi*DATA_WD +: DATA_WD] = mem[head + PTR_W'(gi)];
  end
endmodule

// File: tb/tb_instr_queue_mp.sv
// Self-checking bench for instr_queue_mp: table-driven vectors, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_instr_queue_mp;
  import instr_queue_mp_pkg::*;

  localparam int DW = IQ_DATA_WD;
  localparam int DP = IQ_DEPTH;
  localparam int PW = IQ_PUSH_W;
  localparam int QW = IQ_POP_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_queue_mp_if bus ();
  instr_queue_mp dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] model_q[$];
  int checks = 0;
  int errors = 0;
  int proto_flags = 0;
  bit verbose = 1'b1;

  typedef struct {
    bit         flush;
    int         push_num;
    int         pop_num;
    int         exp_count;
    bit         exp_ready;
    bit         exp_full;
    logic [1:0] exp_valid;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [DW-1:0] mk(input int tag);
    logic [DW-1:0] e;
    e = '0;
    e[IQ_INSTR_LSB +: IQ_INSTR_WD] = 32'hA500_0000 | 32'(tag);
    e[IQ_PC_LSB +: IQ_PC_WD]       = 24'(tag * 4);
    e[IQ_PD_LSB +: IQ_PD_WD]       = 8'(tag ^ 8'h3C);
    return e;
  endfunction

  function automatic logic [PW*DW-1:0] mk_bundle(input int base);
    logic [PW*DW-1:0] d;
    for (int i = 0; i < PW; i++) d[i*DW +: DW] = mk(base + i);
    return d;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model.
  task automatic cycle(input bit fl, input int pn, input int qn, input logic [PW*DW-1:0] d);
    bit rdy;
    int pe;
    bus.flush     = fl;
    bus.push_num  = 3'(pn);
    bus.pop_num   = 2'(qn);
    bus.push_data = d;
    if (!rst && !fl && qn > model_q.size()) begin
      proto_flags++;
      $display("note: pop_num %0d exceeds occupancy %0d (clamped)", qn, model_q.size());
    end
    @(posedge clk);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      rdy = (model_q.size() + PW <= DP);
      pe  = (qn > model_q.size()) ? model_q.size() : qn;
      repeat (pe) void'(model_q.pop_front());
      if (rdy) for (int i = 0; i < pn; i++) model_q.push_back(d[i*DW +: DW]);
    end
    #1;
    if (verbose)
      $display("txn rst=%0b flush=%0b push=%0d pop=%0d -> count=%0d ready=%0b valid=%b",
               rst, fl, pn, qn, bus.count, bus.push_ready, bus.pop_valid);
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"}, DW'(bus.count), DW'(sz));
    chk({tag, ".empty"}, DW'(bus.empty), DW'(sz == 0));
    chk({tag, ".full"},  DW'(bus.full),  DW'(sz == DP));
    chk({tag, ".ready"}, DW'(bus.push_ready), DW'(sz + PW <= DP));
    for (int j = 0; j < QW; j++) begin
      chk($sformatf("%s.valid%0d", tag, j), DW'(bus.pop_valid[j]), DW'(sz > j));
      if (sz > j) chk($sformatf("%s.data%0d", tag, j), bus.pop_data[j*DW +: DW], model_q[j]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    iq_entry_t x;
    logic [PW*DW-1:0] xd;
    int qn;

    bus.flush = 1'b0; bus.push_num = '0; bus.pop_num = '0; bus.push_data = '0;

    // Test 1: reset then idle
    rst = 1'b1;
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, '0);
      check_state($sformatf("idle%0d", i));
    end
    chk("reset.valid", DW'(bus.pop_valid), DW'(2'b00));
    chk("reset.ready", DW'(bus.push_ready), DW'(1));

    // Table: fill to full, backpressure, threshold, flush with push+pop
    vecs[0] = '{0, 4, 0,  4, 1, 0, 2'b11};
    vecs[1] = '{0, 4, 0,  8, 1, 0, 2'b11};
    vecs[2] = '{0, 4, 0, 12, 1, 0, 2'b11};
    vecs[3] = '{0, 4, 0, 16, 0, 1, 2'b11};
    vecs[4] = '{0, 4, 2, 14, 0, 0, 2'b11};
    vecs[5] = '{0, 4, 2, 12, 1, 0, 2'b11};
    vecs[6] = '{0, 1, 0, 13, 0, 0, 2'b11};
    vecs[7] = '{0, 4, 2, 11, 1, 0, 2'b11};
    vecs[8] = '{0, 0, 2,  9, 1, 0, 2'b11};
    vecs[9] = '{1, 3, 2,  0, 1, 0, 2'b00};
    for (int r = 0; r < 10; r++) begin
      cycle(vecs[r].flush, vecs[r].push_num, vecs[r].pop_num, mk_bundle(r * 4));
      chk($sformatf("vec%0d.count", r), DW'(bus.count), DW'(vecs[r].exp_count));
      chk($sformatf("vec%0d.ready", r), DW'(bus.push_ready), DW'(vecs[r].exp_ready));
      chk($sformatf("vec%0d.full", r),  DW'(bus.full), DW'(vecs[r].exp_full));
      chk($sformatf("vec%0d.valid", r), DW'(bus.pop_valid), DW'(vecs[r].exp_valid));
      check_state($sformatf("vec%0d", r));
      if (r == 0) begin
        chk("first_push.slot0", bus.pop_data[0 +: DW], mk(0));
        chk("first_push.slot1", bus.pop_data[DW +: DW], mk(1));
      end
    end

    // Test 4: wrap tail from 14 across the end of the array
    for (int i = 0; i < 3; i++) cycle(0, 4, 0, mk_bundle(50 + i * 4));
    for (int i = 0; i < 6; i++) cycle(0, 0, 2, '0);
    cycle(0, 2, 0, mk_bundle(70));
    cycle(0, 0, 2, '0);
    check_state("wrap.pre");
    cycle(0, 4, 0, mk_bundle(100));
    chk("wrap.E", bus.pop_data[0 +: DW], mk(100));
    chk("wrap.F", bus.pop_data[DW +: DW], mk(101));
    cycle(0, 0, 2, '0);
    chk("wrap.G", bus.pop_data[0 +: DW], mk(102));
    chk("wrap.H", bus.pop_data[DW +: DW], mk(103));
    cycle(0, 0, 2, '0);
    check_state("wrap.post");

    // Test 5: over-pop is clamped and flagged
    cycle(0, 1, 0, mk_bundle(200));
    chk("underflow.valid_pre", DW'(bus.pop_valid), DW'(2'b01));
    cycle(0, 0, 2, '0);
    chk("underflow.count", DW'(bus.count), DW'(0));
    chk("underflow.empty", DW'(bus.empty), DW'(1));
    chk("underflow.flagged", DW'(proto_flags), DW'(1));

    // Test 6: flush beats same-cycle push and pop
    cycle(0, 4, 0, mk_bundle(300));
    cycle(0, 2, 0, mk_bundle(304));
    chk("flush.pre_count", DW'(bus.count), DW'(6));
    cycle(1, 3, 2, mk_bundle(310));
    chk("flush.count", DW'(bus.count), DW'(0));
    chk("flush.empty", DW'(bus.empty), DW'(1));
    x.instr = 32'hDEAD_BEEF; x.pc = 24'h12_3456; x.predecode = 8'h5A;
    xd = '0;
    xd[0 +: DW] = x;
    cycle(0, 1, 0, xd);
    chk("flush.X", bus.pop_data[0 +: DW], DW'(x));
    chk("flush.X_valid", DW'(bus.pop_valid), DW'(2'b01));

    // Randomized run with legal pops and occasional flushes
    verbose = 1'b0;
    for (int n = 0; n < 400; n++) begin
      xd = '0;
      for (int i = 0; i < PW; i++) xd[i*DW +: DW] = {$urandom, $urandom};
      qn = $urandom_range(0, QW);
      if (qn > model_q.size()) qn = model_q.size();
      cycle(($urandom_range(0, 31) == 0), $urandom_range(0, PW), qn, xd);
      check_state($sformatf("rnd%0d", n));
    end
    chk("proto_flags.final", DW'(proto_flags), DW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
